// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit.
// - bit positions inside the 10-bit WB control bundle
// - writeback FSM state type
// - the link register index used by jal
package wb_pkg;

  localparam int unsigned WB_CTL_W = 10;

  localparam int unsigned B_JAL         = 0;
  localparam int unsigned B_LOAD_BYTE   = 1;
  localparam int unsigned B_FPWRITE     = 2;
  localparam int unsigned B_HILO_WRITE  = 3;
  localparam int unsigned B_MULDIV      = 4;
  localparam int unsigned B_FLOAT_WRITE = 5;
  localparam int unsigned B_MEMTOREG64  = 6;
  localparam int unsigned B_MEMTOREG    = 7;
  localparam int unsigned B_REGWRITE    = 8;
  localparam int unsigned B_WRITE32_64  = 9;

  localparam int unsigned LINK_REG = 31;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_writeback_unit_if.sv
// MEM/WB-to-register-file bundle of the writeback unit.
// master : pipeline side (drives the MEM/WB contents, observes writes/stall)
// slave  : writeback unit (consumes MEM/WB, drives the write ports)
// Handshake: an instruction is taken on a rising edge when wb_valid=1 and the
// unit is not finishing the second half of a 64-bit write; while wb_stall=1
// the pipeline must hold MEM/WB unchanged.
// dbg_state exposes the FSM state for observation.
interface wb_writeback_unit_if #(
  parameter int NREG_BITS = 5
);
  import wb_pkg::*;

  logic                  wb_valid;
  logic [WB_CTL_W-1:0]   WB_control_WB;
  logic [31:0]           ALU_WB;
  logic [31:0]           Memory_WB;
  logic [63:0]           OUT_ALU64_WB;
  logic [63:0]           OUT_data64_WB;
  logic [31:0]           PC_plus8_WB;
  logic [NREG_BITS-1:0]  RegWr_WB;

  logic                  gpr_we;
  logic [NREG_BITS-1:0]  gpr_waddr;
  logic [31:0]           gpr_wdata;
  logic                  fpr_we;
  logic [NREG_BITS-1:0]  fpr_waddr;
  logic [31:0]           fpr_wdata;
  logic                  hi_we;
  logic [31:0]           hi_wdata;
  logic                  lo_we;
  logic [31:0]           lo_wdata;
  logic                  fcc;
  logic                  wb_stall;
  wb_state_t             dbg_state;

  modport master (
    output wb_valid, WB_control_WB, ALU_WB, Memory_WB, OUT_ALU64_WB,
           OUT_data64_WB, PC_plus8_WB, RegWr_WB,
    input  gpr_we, gpr_waddr, gpr_wdata, fpr_we, fpr_waddr, fpr_wdata,
           hi_we, hi_wdata, lo_we, lo_wdata, fcc, wb_stall, dbg_state
  );

  modport slave (
    input  wb_valid, WB_control_WB, ALU_WB, Memory_WB, OUT_ALU64_WB,
           OUT_data64_WB, PC_plus8_WB, RegWr_WB,
    output gpr_we, gpr_waddr, gpr_wdata, fpr_we, fpr_waddr, fpr_wdata,
           hi_we, hi_wdata, lo_we, lo_wdata, fcc, wb_stall, dbg_state
  );

endinterface

// File: rtl/wb_data_select.sv
// Combinational result source selection for writeback.
// Ports:
//   jal_i, load_byte_i, memtoreg_i, memtoreg64_i : decoded control bits
//   alu_i, mem_i, pc8_i                           : 32-bit candidates
//   alu64_i, data64_i                             : 64-bit candidates
//   src32_o : jal link > load data (optionally sign-extended byte) > ALU
//   src64_o : 64-bit load data or 64-bit ALU result
module wb_data_select (
  input  logic        jal_i,
  input  logic        load_byte_i,
  input  logic        memtoreg_i,
  input  logic        memtoreg64_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] mem_i,
  input  logic [31:0] pc8_i,
  input  logic [63:0] alu64_i,
  input  logic [63:0] data64_i,
  output logic [31:0] src32_o,
  output logic [63:0] src64_o
);

  logic [31:0] load32;

  always_comb begin
    load32 = load_byte_i ? {{24{mem_i[7]}}, mem_i[7:0]} : mem_i;
    if (jal_i) begin
      src32_o = pc8_i;
    end else if (memtoreg_i) begin
      src32_o = load32;
    end else begin
      src32_o = alu_i;
    end
    src64_o = memtoreg64_i ? data64_i : alu64_i;
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback stage: decodes the WB control bundle of the MEM/WB register and
// issues registered writes to the GPR, FPR, HI/LO and FP condition flag.
// 64-bit results go to an even/odd FPR pair over two cycles through the
// single FPR port; wb_stall holds the pipeline for the extra cycle.
// Ports:
//   Clk : rising-edge clock
//   Rst : asynchronous active-high reset
//   wb  : MEM/WB inputs, register-file write ports, wb_stall, dbg_state
module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int NREG_BITS = 5
) (
  input logic                Clk,
  input logic                Rst,
  wb_writeback_unit_if.slave wb
);

  logic [WB_CTL_W-1:0]  ctl;
  logic                 is_w64;
  logic [NREG_BITS-1:0] dest;
  logic [31:0]          src32;
  logic [63:0]          src64;

  assign ctl    = wb.WB_control_WB;
  assign is_w64 = ctl[B_REGWRITE] & ctl[B_WRITE32_64];
  assign dest   = ctl[B_JAL] ? NREG_BITS'(LINK_REG) : wb.RegWr_WB;

  wb_data_select u_sel (
    .jal_i        (ctl[B_JAL]),
    .load_byte_i  (ctl[B_LOAD_BYTE]),
    .memtoreg_i   (ctl[B_MEMTOREG]),
    .memtoreg64_i (ctl[B_MEMTOREG64]),
    .alu_i        (wb.ALU_WB),
    .mem_i        (wb.Memory_WB),
    .pc8_i        (wb.PC_plus8_WB),
    .alu64_i      (wb.OUT_ALU64_WB),
    .data64_i     (wb.OUT_data64_WB),
    .src32_o      (src32),
    .src64_o      (src64)
  );

  wb_state_t            state_q, state_d;
  logic                 gpr_we_q, gpr_we_d;
  logic [NREG_BITS-1:0] gpr_waddr_q, gpr_waddr_d;
  logic [31:0]          gpr_wdata_q, gpr_wdata_d;
  logic                 fpr_we_q, fpr_we_d;
  logic [NREG_BITS-1:0] fpr_waddr_q, fpr_waddr_d;
  logic [31:0]          fpr_wdata_q, fpr_wdata_d;
  logic                 hi_we_q, hi_we_d;
  logic [31:0]          hi_wdata_q, hi_wdata_d;
  logic                 lo_we_q, lo_we_d;
  logic [31:0]          lo_wdata_q, lo_wdata_d;
  logic                 fcc_q, fcc_d;
  // High half of a 64-bit result, parked until the SECOND cycle.
  logic [NREG_BITS-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]          pend_data_q, pend_data_d;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      gpr_we_q    <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
      fpr_we_q    <= 1'b0;
      fpr_waddr_q <= '0;
      fpr_wdata_q <= '0;
      hi_we_q     <= 1'b0;
      hi_wdata_q  <= '0;
      lo_we_q     <= 1'b0;
      lo_wdata_q  <= '0;
      fcc_q       <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      gpr_we_q    <= gpr_we_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
      fpr_we_q    <= fpr_we_d;
      fpr_waddr_q <= fpr_waddr_d;
      fpr_wdata_q <= fpr_wdata_d;
      hi_we_q     <= hi_we_d;
      hi_wdata_q  <= hi_wdata_d;
      lo_we_q     <= lo_we_d;
      lo_wdata_q  <= lo_wdata_d;
      fcc_q       <= fcc_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gpr_we_d    = 1'b0;
    gpr_waddr_d = gpr_waddr_q;
    gpr_wdata_d = gpr_wdata_q;
    fpr_we_d    = 1'b0;
    fpr_waddr_d = fpr_waddr_q;
    fpr_wdata_d = fpr_wdata_q;
    hi_we_d     = 1'b0;
    hi_wdata_d  = hi_wdata_q;
    lo_we_d     = 1'b0;
    lo_wdata_d  = lo_wdata_q;
    fcc_d       = fcc_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;

    case (state_q)
      IDLE: begin
        if (wb.wb_valid) begin
          if (ctl[B_FLOAT_WRITE]) begin
            fcc_d = wb.ALU_WB[0];
          end

          if (is_w64) begin
            fpr_we_d    = 1'b1;
            fpr_waddr_d = {wb.RegWr_WB[NREG_BITS-1:1], 1'b0};
            fpr_wdata_d = src64[31:0];
            pend_addr_d = {wb.RegWr_WB[NREG_BITS-1:1], 1'b1};
            pend_data_d = src64[63:32];
            state_d     = SECOND;
          end else if (ctl[B_REGWRITE] && ctl[B_FPWRITE]) begin
            fpr_we_d    = 1'b1;
            fpr_waddr_d = dest;
            fpr_wdata_d = src32;
          end else if (ctl[B_REGWRITE]) begin
            // r0 is hardwired to zero, so its write is dropped.
            gpr_we_d    = (dest != '0);
            gpr_waddr_d = dest;
            gpr_wdata_d = src32;
          end

          if (ctl[B_MULDIV]) begin
            hi_we_d    = 1'b1;
            hi_wdata_d = wb.OUT_ALU64_WB[63:32];
            lo_we_d    = 1'b1;
            lo_wdata_d = wb.OUT_ALU64_WB[31:0];
          end else if (ctl[B_HILO_WRITE]) begin
            // mthi/mtlo: bit 0 of the destination field selects HI.
            if (wb.RegWr_WB[0]) begin
              hi_we_d    = 1'b1;
              hi_wdata_d = wb.ALU_WB;
            end else begin
              lo_we_d    = 1'b1;
              lo_wdata_d = wb.ALU_WB;
            end
          end
        end
      end
      SECOND: begin
        // Input is ignored here; upstream is still stalled.
        fpr_we_d    = 1'b1;
        fpr_waddr_d = pend_addr_q;
        fpr_wdata_d = pend_data_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb.wb_stall  = (state_q == SECOND) | ((state_q == IDLE) & wb.wb_valid & is_w64);
  assign wb.gpr_we    = gpr_we_q;
  assign wb.gpr_waddr = gpr_waddr_q;
  assign wb.gpr_wdata = gpr_wdata_q;
  assign wb.fpr_we    = fpr_we_q;
  assign wb.fpr_waddr = fpr_waddr_q;
  assign wb.fpr_wdata = fpr_wdata_q;
  assign wb.hi_we     = hi_we_q;
  assign wb.hi_wdata  = hi_wdata_q;
  assign wb.lo_we     = lo_we_q;
  assign wb.lo_wdata  = lo_wdata_q;
  assign wb.fcc       = fcc_q;
  assign wb.dbg_state = state_q;

endmodule

// File: tb/tb_wb_writeback_unit.sv
module tb_wb_writeback_unit;
  import wb_pkg::*;

  typedef struct packed {
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        fpr_we;
    logic [4:0]  fpr_waddr;
    logic [31:0] fpr_wdata;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic        fcc;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  wb_writeback_unit_if #(.NREG_BITS(5)) wbif ();

  wb_writeback_unit #(.NREG_BITS(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .wb  (wbif)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  logic mon_prev_fcc = 1'b0;
  logic model_fcc = 1'b0;
  logic prev64 = 1'b0;

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    exp_t e;
    if (mon_en && !Rst) begin
      if (wbif.gpr_we || wbif.fpr_we || wbif.hi_we || wbif.lo_we || (wbif.fcc !== mon_prev_fcc)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: gpr_we=%b fpr_we=%b hi_we=%b lo_we=%b fcc=%b, none expected",
                   wbif.gpr_we, wbif.fpr_we, wbif.hi_we, wbif.lo_we, wbif.fcc);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check1("gpr_we", 64'(wbif.gpr_we), 64'(e.gpr_we));
          if (e.gpr_we) begin
            check1("gpr_waddr", 64'(wbif.gpr_waddr), 64'(e.gpr_waddr));
            check1("gpr_wdata", 64'(wbif.gpr_wdata), 64'(e.gpr_wdata));
          end
          check1("fpr_we", 64'(wbif.fpr_we), 64'(e.fpr_we));
          if (e.fpr_we) begin
            check1("fpr_waddr", 64'(wbif.fpr_waddr), 64'(e.fpr_waddr));
            check1("fpr_wdata", 64'(wbif.fpr_wdata), 64'(e.fpr_wdata));
          end
          check1("hi_we", 64'(wbif.hi_we), 64'(e.hi_we));
          if (e.hi_we) check1("hi_wdata", 64'(wbif.hi_wdata), 64'(e.hi_wdata));
          check1("lo_we", 64'(wbif.lo_we), 64'(e.lo_we));
          if (e.lo_we) check1("lo_wdata", 64'(wbif.lo_wdata), 64'(e.lo_wdata));
          check1("fcc", 64'(wbif.fcc), 64'(e.fcc));
        end
      end
    end
    mon_prev_fcc = wbif.fcc;
  end

  // ---------------- reference model ----------------
  // Derives the architectural writes of one instruction from the decode rules.
  task automatic model_push(input logic [9:0] ctl, input logic [31:0] alu, input logic [31:0] mem,
                            input logic [63:0] a64, input logic [63:0] d64, input logic [31:0] pc8,
                            input logic [4:0] rd);
    exp_t e;
    logic [31:0] val;
    logic [63:0] v64;
    logic [4:0] dst;
    logic fcc_before;
    bit regw, w64;
    regw = ctl[8];
    w64  = ctl[9];
    fcc_before = model_fcc;
    e = '0;

    if (ctl[0])      val = pc8;
    else if (ctl[7]) val = ctl[1] ? 32'($signed(mem[7:0])) : mem;
    else             val = alu;
    dst = ctl[0] ? 5'd31 : rd;
    v64 = ctl[6] ? d64 : a64;

    if (regw && w64) begin
      e.fpr_we = 1'b1; e.fpr_waddr = rd & 5'b11110; e.fpr_wdata = v64[31:0];
    end else if (regw && ctl[2]) begin
      e.fpr_we = 1'b1; e.fpr_waddr = dst; e.fpr_wdata = val;
    end else if (regw && dst != 0) begin
      e.gpr_we = 1'b1; e.gpr_waddr = dst; e.gpr_wdata = val;
    end

    if (ctl[4]) begin
      e.hi_we = 1'b1; e.hi_wdata = a64[63:32];
      e.lo_we = 1'b1; e.lo_wdata = a64[31:0];
    end else if (ctl[3]) begin
      if (rd[0]) begin e.hi_we = 1'b1; e.hi_wdata = alu; end
      else       begin e.lo_we = 1'b1; e.lo_wdata = alu; end
    end

    if (ctl[5]) model_fcc = alu[0];
    e.fcc = model_fcc;
    if (e.gpr_we || e.fpr_we || e.hi_we || e.lo_we || model_fcc != fcc_before)
      exp_q.push_back(EXP_W'(e));

    if (regw && w64) begin
      e = '0;
      e.fpr_we = 1'b1; e.fpr_waddr = rd | 5'b00001; e.fpr_wdata = v64[63:32];
      e.fcc = model_fcc;
      exp_q.push_back(EXP_W'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [9:0] ctl, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [63:0] a64, input logic [63:0] d64, input logic [31:0] pc8,
                      input logic [4:0] rd);
    bit is64;
    int edges;
    @(negedge Clk);
    wbif.wb_valid      = 1'b1;
    wbif.WB_control_WB = ctl;
    wbif.ALU_WB        = alu;
    wbif.Memory_WB     = mem;
    wbif.OUT_ALU64_WB  = a64;
    wbif.OUT_data64_WB = d64;
    wbif.PC_plus8_WB   = pc8;
    wbif.RegWr_WB      = rd;
    is64 = ctl[8] && ctl[9];
    #1;
    check1("wb_stall", 64'(wbif.wb_stall), 64'(is64 || prev64));
    model_push(ctl, alu, mem, a64, d64, pc8, rd);
    // After a 64-bit instruction the unit spends one edge on the high half.
    edges = prev64 ? 2 : 1;
    repeat (edges) @(posedge Clk);
    prev64 = is64;
  endtask

  task automatic bubble();
    @(negedge Clk);
    wbif.wb_valid      = 1'b0;
    wbif.WB_control_WB = 10'($urandom_range(0, 1023));
    wbif.ALU_WB        = $urandom;
    #1;
    check1("wb_stall_bubble", 64'(wbif.wb_stall), 64'(prev64));
    @(posedge Clk);
    prev64 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wbif.wb_valid      = 1'b0;
    wbif.WB_control_WB = '0;
    wbif.ALU_WB        = '0;
    wbif.Memory_WB     = '0;
    wbif.OUT_ALU64_WB  = '0;
    wbif.OUT_data64_WB = '0;
    wbif.PC_plus8_WB   = '0;
    wbif.RegWr_WB      = '0;

    // reset state
    #12;
    check1("rst_gpr_we", 64'(wbif.gpr_we), 64'd0);
    check1("rst_fpr_we", 64'(wbif.fpr_we), 64'd0);
    check1("rst_hi_we", 64'(wbif.hi_we), 64'd0);
    check1("rst_lo_we", 64'(wbif.lo_we), 64'd0);
    check1("rst_gpr_wdata", 64'(wbif.gpr_wdata), 64'd0);
    check1("rst_fpr_waddr", 64'(wbif.fpr_waddr), 64'd0);
    check1("rst_fcc", 64'(wbif.fcc), 64'd0);
    check1("rst_stall", 64'(wbif.wb_stall), 64'd0);
    check1("rst_state", 64'(wbif.dbg_state), 64'(IDLE));
    @(negedge Clk);
    Rst = 1'b0;
    mon_en = 1'b1;

    // directed cases
    send(10'h182, 32'h0, 32'h0000_00F3, 64'h0, 64'h0, 32'h0, 5'd5);   // load byte -> r5
    send(10'h182, 32'h0, 32'h0000_00F3, 64'h0, 64'h0, 32'h0, 5'd0);   // load byte -> r0 dropped
    send(10'h340, 32'h0, 32'h0, 64'h0, 64'h1111_2222_3333_4444, 32'h0, 5'd7); // 64-bit pair
    send(10'h101, 32'h0, 32'h0, 64'h0, 64'h0, 32'h0040_0010, 5'd9);   // jal
    send(10'h010, 32'h0, 32'h0, 64'hDEAD_BEEF_0000_0001, 64'h0, 32'h0, 5'd0); // mult
    send(10'h020, 32'h1, 32'h0, 64'h0, 64'h0, 32'h0, 5'd0);           // fcc <- 1
    send(10'h008, 32'hCAFE_0001, 32'h0, 64'h0, 64'h0, 32'h0, 5'd1);   // mthi
    send(10'h008, 32'hCAFE_0002, 32'h0, 64'h0, 64'h0, 32'h0, 5'd2);   // mtlo
    send(10'h104, 32'h1234_5678, 32'h0, 64'h0, 64'h0, 32'h0, 5'd3);   // 32-bit FPR
    send(10'h300, 32'h0, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 32'h0, 5'd4); // 64-bit ALU
    send(10'h300, 32'h0, 32'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 32'h0, 5'd11); // back-to-back 64
    bubble();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) bubble();
      else send(10'($urandom_range(0, 1023)), $urandom, $urandom, {$urandom, $urandom},
                {$urandom, $urandom}, $urandom, 5'($urandom_range(0, 31)));
    end
    repeat (3) bubble();
    check1("drain_before_reset", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // reset while the high half is pending
    mon_en = 1'b0;
    @(negedge Clk);
    wbif.wb_valid      = 1'b1;
    wbif.WB_control_WB = 10'h340;
    wbif.OUT_data64_WB = 64'h1111_2222_3333_4444;
    wbif.RegWr_WB      = 5'd7;
    #1;
    check1("r2_stall_idle", 64'(wbif.wb_stall), 64'd1);
    @(posedge Clk);
    #1;
    check1("r2_first_we", 64'(wbif.fpr_we), 64'd1);
    check1("r2_first_addr", 64'(wbif.fpr_waddr), 64'd6);
    check1("r2_first_data", 64'(wbif.fpr_wdata), 64'h3333_4444);
    check1("r2_state_second", 64'(wbif.dbg_state), 64'(SECOND));
    #1;
    Rst = 1'b1;
    wbif.wb_valid = 1'b0;
    #1;
    check1("r2_async_fpr_we", 64'(wbif.fpr_we), 64'd0);
    check1("r2_async_addr", 64'(wbif.fpr_waddr), 64'd0);
    check1("r2_async_stall", 64'(wbif.wb_stall), 64'd0);
    check1("r2_async_fcc", 64'(wbif.fcc), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check1("r2_no_high_write", 64'(wbif.fpr_we), 64'd0);
    check1("r2_state_idle", 64'(wbif.dbg_state), 64'(IDLE));
    check1("r2_stall_after", 64'(wbif.wb_stall), 64'd0);
    model_fcc = 1'b0;
    prev64 = 1'b0;
    @(negedge Clk);
    mon_en = 1'b1;

    // recovery after reset
    send(10'h101, 32'h0, 32'h0, 64'h0, 64'h0, 32'h0000_1234, 5'd2);
    send(10'h340, 32'h0, 32'h0, 64'h0, 64'h5555_6666_7777_8888, 32'h0, 5'd7);
    send(10'h100, 32'h0000_0042, 32'h0, 64'h0, 64'h0, 32'h0, 5'd8);
    repeat (3) bubble();
    check1("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
